// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, on magnitudes; signs are applied when the result is written.
module mips_muldiv_unit #(
  parameter int DWL = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2:0]     op,
  input  logic           flush,
  input  logic [DWL-1:0] A,
  input  logic [DWL-1:0] B,
  output logic           busy,
  output logic           done,
  output logic [DWL-1:0] HI,
  output logic [DWL-1:0] LO
);

  localparam int CW = $clog2(DWL);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  count;
  logic [DWL-1:0] acc_hi;   // running upper product / partial remainder
  logic [DWL-1:0] acc_lo;   // multiplier bits / dividend bits, becomes low product / quotient
  logic [DWL-1:0] mcand;    // multiplicand or divisor magnitude
  logic           is_div, neg_res, neg_rem, div_zero;

  logic           signed_op, accept, mt_write;
  logic [DWL-1:0] a_mag, b_mag;
  logic [DWL:0]   mul_sum, trial, diff;
  logic           q_bit;
  logic [2*DWL-1:0] prod, prod_s;
  logic [DWL-1:0] quo_s, rem_s, fin_hi, fin_lo;

  assign signed_op = ~op[0];
  assign accept    = (state == S_IDLE) && start && !flush && !op[2];
  assign mt_write  = (state == S_IDLE) && start && !flush && (op == 3'd4 || op == 3'd5);
  assign a_mag     = (signed_op && A[DWL-1]) ? -A : A;
  assign b_mag     = (signed_op && B[DWL-1]) ? -B : B;

  // One iteration of each algorithm
  assign mul_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? mcand : {DWL{1'b0}})};
  assign trial   = {acc_hi, acc_lo[DWL-1]};
  assign diff    = trial - {1'b0, mcand};
  assign q_bit   = ~diff[DWL];

  // Sign correction applied in FIN
  assign prod   = {acc_hi, acc_lo};
  assign prod_s = neg_res ? -prod : prod;
  assign quo_s  = neg_res ? -acc_lo : acc_lo;
  assign rem_s  = neg_rem ? -acc_hi : acc_hi;
  assign fin_hi = is_div ? rem_s : prod_s[2*DWL-1:DWL];
  assign fin_lo = is_div ? (div_zero ? {DWL{1'b1}} : quo_s) : prod_s[DWL-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    case (state)
      S_IDLE: if (accept) state_next = S_RUN;
      S_RUN: begin
        if (flush)              state_next = S_IDLE;
        else if (count == '0)   state_next = S_FIN;
      end
      S_FIN: begin
        done       = !flush;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      mcand    <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else if (accept) begin
      count    <= CW'(DWL-1);
      is_div   <= op[1];
      neg_res  <= signed_op & (A[DWL-1] ^ B[DWL-1]);
      neg_rem  <= signed_op & A[DWL-1];
      div_zero <= op[1] & (B == '0);
      acc_hi   <= '0;
      acc_lo   <= op[1] ? a_mag : b_mag;
      mcand    <= op[1] ? b_mag : a_mag;
    end else if (state == S_RUN && !flush) begin
      count <= count - CW'(1);
      if (is_div) begin
        acc_hi <= q_bit ? diff[DWL-1:0] : trial[DWL-1:0];
        acc_lo <= {acc_lo[DWL-2:0], q_bit};
      end else begin
        acc_hi <= mul_sum[DWL:1];
        acc_lo <= {mul_sum[0], acc_lo[DWL-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      HI <= '0;
      LO <= '0;
    end else if (state == S_FIN && !flush) begin
      HI <= fin_hi;
      LO <= fin_lo;
    end else if (mt_write) begin
      if (op == 3'd4) HI <= A;
      else            LO <= A;
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Randomised and directed bench for mips_muldiv_unit against a 64-bit arithmetic reference model.
module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi, exp_lo;

  mips_muldiv_unit #(.DWL(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .flush(flush),
    .A(A), .B(B), .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // Reference: {HI,LO} from the instruction's arithmetic meaning
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, m;
    longint unsigned ua, ub;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = '0;
    case (o)
      3'd0: r = sa * sb;
      3'd1: r = ua * ub;
      3'd2: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          m = sa % sb;
          r = {m[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else r = {32'(ua % ub), 32'(ua / ub)};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Issue one MULT/DIV op; lat = cycles after the accepting edge until done, -1 on timeout.
  // Returns at the negedge after done, when HI/LO hold the result.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
    @(negedge clk);
    start = 1'b1; op = o; A = x; B = y;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd7; A = '0; B = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (HI !== 32'h0 || LO !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: HI=%h LO=%h busy=%b done=%b, want 0/0/0/0", HI, LO, busy, done);
    end
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_directed;
    logic [2:0]  ops [6] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd2, 3'd3};
    logic [31:0] as  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd50};
    logic [31:0] bs  [6] = '{32'd2, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd7};
    logic [63:0] e;
    int lat;
    for (int i = 0; i < 6; i++) begin
      e = model(ops[i], as[i], bs[i]);
      do_op(ops[i], as[i], bs[i], lat);
      $display("directed op=%0d A=%h B=%h -> HI=%h LO=%h lat=%0d", ops[i], as[i], bs[i], HI, LO, lat);
      checks++;
      if (lat !== 33) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d, want 33", i, lat);
      end
      checks++;
      if ({HI, LO} !== e) begin
        errors++;
        $display("FAIL directed_result[%0d]: got %h_%h, want %h_%h", i, HI, LO, e[63:32], e[31:0]);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL directed_busy_clear[%0d]: got %b, want 0", i, busy);
      end
      exp_hi = e[63:32]; exp_lo = e[31:0];
    end
    // Spec reference vectors pinned as constants to guard the model itself
    checks++;
    if (model(3'd1, 32'hFFFF_FFFF, 32'd2) !== 64'h0000_0001_FFFF_FFFE || model(3'd2, 32'hFFFF_FFF9, 32'd2) !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++;
      $display("FAIL model_sanity: reference model disagrees with known vectors");
    end
  endtask

  task automatic test_mt;
    int lat;
    @(negedge clk);
    start = 1'b1; op = 3'd4; A = 32'h1234;
    @(negedge clk);
    start = 1'b0;
    $display("mthi A=00001234 -> HI=%h busy=%b done=%b", HI, busy, done);
    checks++;
    if (HI !== 32'h1234 || LO !== exp_lo || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi: HI=%h LO=%h done=%b busy=%b, want HI=00001234 LO=%h 0 0", HI, LO, done, busy, exp_lo);
    end
    exp_hi = 32'h1234;
    start = 1'b1; op = 3'd5; A = 32'hCAFE_0001;
    @(negedge clk);
    start = 1'b1; op = 3'd6; A = 32'h5555_5555;
    $display("mtlo A=cafe0001 -> LO=%h", LO);
    checks++;
    if (LO !== 32'hCAFE_0001 || HI !== exp_hi) begin
      errors++;
      $display("FAIL mtlo: HI=%h LO=%h, want %h cafe0001", HI, LO, exp_hi);
    end
    exp_lo = 32'hCAFE_0001;
    @(negedge clk);
    start = 1'b0;
    $display("noop op=6 -> HI=%h LO=%h busy=%b", HI, LO, busy);
    checks++;
    if (HI !== exp_hi || LO !== exp_lo || busy !== 1'b0) begin
      errors++;
      $display("FAIL noop: HI=%h LO=%h busy=%b, want %h %h 0", HI, LO, busy, exp_hi, exp_lo);
    end
    // MTLO issued while a MULTU is running must be dropped
    start = 1'b1; op = 3'd1; A = 32'd5; B = 32'd6;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 3'd5; A = 32'hDEAD_BEEF; B = 32'd0;
    @(negedge clk);
    start = 1'b0;
    $display("mtlo while busy -> LO=%h busy=%b", LO, busy);
    checks++;
    if (LO !== exp_lo || busy !== 1'b1) begin
      errors++;
      $display("FAIL mtlo_busy: LO=%h busy=%b, want %h 1", LO, busy, exp_lo);
    end
    lat = -1;
    for (int k = 3; k <= 40; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    $display("multu 5*6 after ignored mtlo -> HI=%h LO=%h lat=%0d", HI, LO, lat);
    checks++;
    if (lat !== 33 || HI !== 32'd0 || LO !== 32'd30) begin
      errors++;
      $display("FAIL mtlo_busy_result: HI=%h LO=%h lat=%0d, want 0 1e 33", HI, LO, lat);
    end
    exp_hi = 32'd0; exp_lo = 32'd30;
  endtask

  task automatic test_flush;
    int lat;
    logic seen_done;
    seen_done = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 3'd3; A = 32'd50; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 10; k++) begin
      seen_done |= done;
      @(negedge clk);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    seen_done |= done;
    $display("divu 50/7 flushed -> busy=%b HI=%h LO=%h", busy, HI, LO);
    checks++;
    if (busy !== 1'b0 || seen_done !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
      errors++;
      $display("FAIL flush: busy=%b done_seen=%b HI=%h LO=%h, want 0 0 %h %h", busy, seen_done, HI, LO, exp_hi, exp_lo);
    end
    repeat (40) begin
      seen_done |= done;
      @(negedge clk);
    end
    checks++;
    if (seen_done !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
      errors++;
      $display("FAIL flush_late_done: done_seen=%b HI=%h LO=%h", seen_done, HI, LO);
    end
    // flush with a simultaneous start: start must be ignored
    start = 1'b1; op = 3'd4; A = 32'h0BAD_0BAD; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++;
    if (HI !== exp_hi || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_start: HI=%h busy=%b, want %h 0", HI, busy, exp_hi);
    end
    do_op(3'd3, 32'd50, 32'd7, lat);
    $display("divu 50/7 after flush -> HI=%h LO=%h lat=%0d", HI, LO, lat);
    checks++;
    if (lat !== 33 || HI !== 32'd1 || LO !== 32'd7) begin
      errors++;
      $display("FAIL flush_retry: HI=%h LO=%h lat=%0d, want 1 7 33", HI, LO, lat);
    end
    exp_hi = 32'd1; exp_lo = 32'd7;
  endtask

  task automatic test_reset_midop;
    @(negedge clk);
    start = 1'b1; op = 3'd0; A = 32'h1234_5678; B = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset mid-op -> HI=%h LO=%h busy=%b", HI, LO, busy);
    checks++;
    if (HI !== 32'h0 || LO !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_midop: HI=%h LO=%h busy=%b done=%b, want 0 0 0 0", HI, LO, busy, done);
    end
    exp_hi = '0; exp_lo = '0;
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] specials [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  task automatic test_random;
    logic [2:0]  o;
    logic [31:0] x, y;
    logic [63:0] e;
    int lat;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 3));
      x = pick_operand();
      y = pick_operand();
      e = model(o, x, y);
      do_op(o, x, y, lat);
      $display("random[%0d] op=%0d A=%h B=%h -> HI=%h LO=%h lat=%0d", i, o, x, y, HI, LO, lat);
      checks++;
      if (lat !== 33 || {HI, LO} !== e) begin
        errors++;
        $display("FAIL random[%0d]: got %h_%h lat=%0d, want %h_%h lat=33", i, HI, LO, lat, e[63:32], e[31:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mt();
    test_flush();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
